// File: rtl/dac_pkg.sv
// Shared DAC word layout and command/address constants for the pacer and
// the SPI driver side.
package dac_pkg;

  localparam int DAC_WORD_W = 24;
  localparam int SAMPLE_W   = 12;

  typedef logic [SAMPLE_W-1:0]   sample_t;
  typedef logic [DAC_WORD_W-1:0] dac_word_t;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

  localparam logic [3:0] ADDR_A   = 4'b0000;
  localparam logic [3:0] ADDR_B   = 4'b0001;
  localparam logic [3:0] ADDR_C   = 4'b0010;
  localparam logic [3:0] ADDR_D   = 4'b0011;
  localparam logic [3:0] ADDR_ALL = 4'b1111;

  // Sample sits at [15:4] untouched; the low nibble is don't-care padding, driven zero.
  function automatic dac_word_t dac_word(input logic [3:0] cmd,
                                         input logic [3:0] addr,
                                         input sample_t    sample);
    return {cmd, addr, sample, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_sample_pacer_if.sv
// Sample-in / DAC-word-out bus of the pacer; slave is the pacer, master is
// whoever drives the signal samples and the SPI ready.
interface dac_sample_pacer_if
  import dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               enable;
  sample_t            sig_in;
  logic               sig_valid;
  logic               dac_ready;
  dac_word_t          word_out;
  logic               word_valid;
  logic [LEVEL_W-1:0] fifo_level;
  logic [7:0]         overflow_cnt;

  modport master (
    output enable, sig_in, sig_valid, dac_ready,
    input  word_out, word_valid, fifo_level, overflow_cnt
  );

  modport slave (
    input  enable, sig_in, sig_valid, dac_ready,
    output word_out, word_valid, fifo_level, overflow_cnt
  );

endinterface

// File: rtl/dac_sample_pacer_fifo.sv
// Single-clock FIFO with occupancy count; head is read combinationally.
// The caller must not push while full unless it also pops.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/dac_sample_pacer.sv
// Decimates the summed signal to a fixed sample rate, queues samples and
// hands formatted DAC words to the SPI driver over valid/ready.
module dac_sample_pacer
  import dac_pkg::*;
#(
  parameter int         CLK_DIV    = 1000,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] DAC_CMD    = CMD_WRITE_UPDATE,
  parameter logic [3:0] DAC_ADDR   = ADDR_ALL
) (
  input logic               clk,
  input logic               reset,
  dac_sample_pacer_if.slave bus
);

  localparam int          LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TC = 16'(CLK_DIV - 1);

  logic [15:0]   tick_cnt;
  logic          tick;
  logic          capture;
  logic          load;
  logic          push;
  logic          drop;
  sample_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;
  dac_word_t     word_q;
  logic          valid_q;
  logic [7:0]    ovf_q;

  // Held at zero while disabled so re-enabling always waits a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tick_cnt <= '0;
    else if (!bus.enable || tick_cnt == TC)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  assign tick    = bus.enable && (tick_cnt == TC);
  assign capture = tick && bus.sig_valid;
  assign load    = (!valid_q || bus.dac_ready) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = capture && (!fifo_full || load);
  assign drop    = capture && fifo_full && !load;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.sig_in),
    .pop   (load),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= dac_word(DAC_CMD, DAC_ADDR, head);
      valid_q <= 1'b1;
    end else if (bus.dac_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_q <= '0;
    else if (drop && ovf_q != 8'hFF)
      ovf_q <= ovf_q + 8'd1;
  end

  assign bus.word_out     = word_q;
  assign bus.word_valid   = valid_q;
  assign bus.fifo_level   = level;
  assign bus.overflow_cnt = ovf_q;

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
Sits between the signal-sum stage and the DAC SPI driver. Decimates the continuous 12-bit summed signal to a fixed DAC sample rate and buffers samples in a small FIFO. Each sample is formatted as a 24-bit DAC command word and handed to the SPI driver through a valid/ready handshake. Decouples waveform generation timing from SPI transfer timing and reports dropped samples.

Parameters:
CLK_DIV, 1000, clk cycles per sample tick (50 MHz / 1000 = 50 kS/s); legal range 2..65535
FIFO_DEPTH, 8, sample FIFO entries; power of two, 2..64
DAC_CMD, 4'b0011, command nibble ("write and update")
DAC_ADDR, 4'b1111, address nibble (all channels)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  tick generation enable; when low, no new samples are captured
sig_in  in  12  summed signal sample, unsigned
sig_valid  in  1  sig_in is valid this cycle
dac_ready  in  1  SPI driver can accept a word this cycle
word_out  out  24  {DAC_CMD, DAC_ADDR, sample[11:0], 4'b0000}
word_valid  out  1  word_out holds a valid word
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow_cnt  out  8  dropped-sample count, saturating

Behaviour:
- Reset (async assert, sync deassert by design): tick counter=0, FIFO empty, fifo_level=0, word_valid=0, word_out=0, overflow_cnt=0. Reset mid-transfer discards the FIFO and the output register. Nothing is replayed.
- Tick counter: while enable=1, counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle the count equals CLK_DIV-1. While enable=0, the counter is held at 0 and tick=0. Re-enabling restarts the full CLK_DIV period.
- Capture: on tick & sig_valid, push sig_in. On tick & !sig_valid, nothing is pushed and nothing is counted.
- Full: a push attempted while the FIFO is full and no pop happens in the same cycle is dropped. overflow_cnt increments and saturates at 255. A push and a pop in the same cycle while full are both accepted. The level stays at FIFO_DEPTH and the count is unchanged.
- Output register, one stage:
  - Loads from the FIFO head when (!word_valid | (word_valid & dac_ready)) & FIFO not empty.
  - word_valid is cleared when it is accepted and the FIFO is empty.
  - word_out and word_valid are stable while word_valid & !dac_ready.
- Handshake: a transfer occurs on the rising edge where word_valid & dac_ready. The SPI driver may hold dac_ready low indefinitely. When idle, dac_ready may be high while word_valid is low; this is not a transfer.
- Latency: for a tick in cycle N with an empty FIFO and empty output register, fifo_level=1 in cycle N+1, word_valid=1 with that sample in cycle N+2, and fifo_level=0 in N+2.
- Throughput: one word per cycle at most (back-to-back accepts drain one entry per cycle).
- Empty/underrun: word_valid stays low. No repeat of the last word and no error flag.
- enable=0 does not flush: queued samples continue to drain.
- Width rule: the 12-bit sample is placed at bits [15:4] unmodified, and bits [3:0] are zero.

Decomposition:
- Shared package dac_pkg: DAC_WORD_W=24, SAMPLE_W=12, command constants (CMD_WRITE=4'b0000, CMD_UPDATE=4'b0001, CMD_WRITE_UPDATE=4'b0011, CMD_POWER_DOWN=4'b0100), address constants (ADDR_A..ADDR_D, ADDR_ALL=4'b1111).
- One sub-module, sync_fifo: single-clock FIFO, parameterised width and depth. It provides push/pop/full/empty/level, async active-high reset, and has no internal drop logic.
- Tick counter, drop counter and output register live in dac_sample_pacer.

Test Plan:
- Reset/idle: assert reset mid-count with FIFO holding 3 entries -> immediately word_valid=0, fifo_level=0, overflow_cnt=0, word_out=0.
- Basic pacing, CLK_DIV=10, enable=1, sig_valid=1, sig_in=12'hABC, dac_ready=1 -> one word 24'h3FABC0 per 10 cycles, word_valid 2 cycles after each tick, overflow_cnt=0.
- Backpressure: dac_ready=0 for 5 ticks, sig_in=1,2,3,4,5 -> word_out=24'h3F0010 held stable. fifo_level=4 after tick 5. Releasing dac_ready delivers 1..5 in order on consecutive cycles.
- Overflow, FIFO_DEPTH=8: dac_ready=0 for 12 ticks -> output register holds 1 sample, FIFO holds 8, overflow_cnt=3. Ticks 10-12 are lost and the delivered order is ticks 1-9.
- Saturation: dac_ready=0 for 300 ticks with CLK_DIV=2 -> overflow_cnt stops at 255 and does not wrap.
- Enable/valid gating: enable=0 for 50 cycles, then enable=1 -> no pushes while low and first tick exactly CLK_DIV cycles after enable rises. Queued entries drain during enable=0. sig_valid=0 at a tick -> no push, overflow_cnt unchanged.
